// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - trace record types, word sequence and header layout for the RVFI trace buffer
package ibex_pkg;

    typedef struct packed {
        logic [11:0] order;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [4:0]  rd_addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic        trap;
        logic        intr;
        logic        halt;
        logic [1:0]  mode;
        logic        lost;
    } trace_rec_t;

    typedef enum logic [2:0] {
        TRACE_HDR,
        TRACE_PC,
        TRACE_INSN,
        TRACE_WDATA,
        TRACE_MEM
    } trace_word_e;

    localparam int unsigned HDR_RD_LSB    = 27;
    localparam int unsigned HDR_RMASK_LSB = 23;
    localparam int unsigned HDR_WMASK_LSB = 19;
    localparam int unsigned HDR_TRAP_BIT  = 18;
    localparam int unsigned HDR_INTR_BIT  = 17;
    localparam int unsigned HDR_HALT_BIT  = 16;
    localparam int unsigned HDR_MODE_LSB  = 14;
    localparam int unsigned HDR_LOST_BIT  = 13;
    localparam int unsigned HDR_MEM_BIT   = 12;

    function automatic logic rec_has_mem(trace_rec_t r);
        return (|r.rmask) | (|r.wmask);
    endfunction

    function automatic logic [31:0] trace_hdr(trace_rec_t r);
        logic [31:0] h;
        h = '0;
        h[HDR_RD_LSB +: 5]    = r.rd_addr;
        h[HDR_RMASK_LSB +: 4] = r.rmask;
        h[HDR_WMASK_LSB +: 4] = r.wmask;
        h[HDR_TRAP_BIT]       = r.trap;
        h[HDR_INTR_BIT]       = r.intr;
        h[HDR_HALT_BIT]       = r.halt;
        h[HDR_MODE_LSB +: 2]  = r.mode;
        h[HDR_LOST_BIT]       = r.lost;
        h[HDR_MEM_BIT]        = rec_has_mem(r);
        h[11:0]               = r.order;
        return h;
    endfunction

endpackage

// File: rtl/ibex_trace_fifo.sv
// rtl/ibex_trace_fifo.sv - synchronous FIFO of trace records with wrap-bit pointers
module ibex_trace_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  trace_rec_t                 data_i,
    input  logic                       pop_i,
    output trace_rec_t                 data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth):0]     level_o
);
    localparam int unsigned AW = $clog2(Depth);

    trace_rec_t    mem_q [Depth];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the head is only observed while the FIFO is non-empty.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/ibex_rvfi_trace_buffer.sv
// rtl/ibex_rvfi_trace_buffer.sv - captures RVFI retirements and streams them as 32-bit trace words
module ibex_rvfi_trace_buffer
    import ibex_pkg::*;
#(
    parameter int unsigned Depth        = 4,
    parameter int unsigned DropCntWidth = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      trace_en_i,
    input  logic                      rvfi_valid,
    input  logic [63:0]               rvfi_order,
    input  logic [31:0]               rvfi_insn,
    input  logic                      rvfi_trap,
    input  logic                      rvfi_halt,
    input  logic                      rvfi_intr,
    input  logic [1:0]                rvfi_mode,
    input  logic [4:0]                rvfi_rd_addr,
    input  logic [31:0]               rvfi_rd_wdata,
    input  logic [31:0]               rvfi_pc_rdata,
    input  logic [31:0]               rvfi_mem_addr,
    input  logic [3:0]                rvfi_mem_rmask,
    input  logic [3:0]                rvfi_mem_wmask,
    output logic                      trace_valid_o,
    input  logic                      trace_ready_i,
    output logic [31:0]               trace_data_o,
    output logic                      trace_last_o,
    input  logic                      drop_clr_i,
    output logic [DropCntWidth-1:0]   drop_cnt_o,
    output logic [$clog2(Depth):0]    level_o
);
    trace_word_e              state_q, state_d;
    logic                     lost_q, lost_d;
    logic [DropCntWidth-1:0]  drop_cnt_q, drop_cnt_d;

    trace_rec_t  push_rec, head_rec;
    logic        fifo_full, fifo_empty;
    logic        capture, push, drop, hs, pop_rec, head_mem, word_last;
    logic [31:0] word;
    logic        unused_order;

    assign unused_order = ^rvfi_order[63:12];

    assign push_rec = '{order: rvfi_order[11:0], pc: rvfi_pc_rdata, insn: rvfi_insn,
                        rd_wdata: rvfi_rd_wdata, mem_addr: rvfi_mem_addr,
                        rd_addr: rvfi_rd_addr, rmask: rvfi_mem_rmask,
                        wmask: rvfi_mem_wmask, trap: rvfi_trap, intr: rvfi_intr,
                        halt: rvfi_halt, mode: rvfi_mode, lost: lost_q};

    ibex_trace_fifo #(.Depth(Depth)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_rec),
        .pop_i   (pop_rec),
        .data_o  (head_rec),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    assign head_mem = rec_has_mem(head_rec);

    always_comb begin
        word      = '0;
        word_last = 1'b0;
        state_d   = state_q;
        case (state_q)
            TRACE_HDR:   word = trace_hdr(head_rec);
            TRACE_PC:    word = head_rec.pc;
            TRACE_INSN:  word = head_rec.insn;
            TRACE_WDATA: begin
                word      = (head_rec.rd_addr == 5'd0) ? 32'd0 : head_rec.rd_wdata;
                word_last = !head_mem;
            end
            TRACE_MEM: begin
                word      = head_rec.mem_addr;
                word_last = 1'b1;
            end
            default: word = '0;
        endcase
        if (hs) begin
            case (state_q)
                TRACE_HDR:   state_d = TRACE_PC;
                TRACE_PC:    state_d = TRACE_INSN;
                TRACE_INSN:  state_d = TRACE_WDATA;
                TRACE_WDATA: state_d = head_mem ? TRACE_MEM : TRACE_HDR;
                default:     state_d = TRACE_HDR;
            endcase
        end
    end

    assign trace_valid_o = !fifo_empty;
    assign trace_data_o  = trace_valid_o ? word : 32'd0;
    assign trace_last_o  = trace_valid_o & word_last;
    assign hs            = trace_valid_o & trace_ready_i;
    assign pop_rec       = hs & word_last;

    // A completing record frees its slot in the same cycle, so a full FIFO may still accept.
    assign capture = rvfi_valid & trace_en_i;
    assign push    = capture & (!fifo_full | pop_rec);
    assign drop    = capture & fifo_full & !pop_rec;

    always_comb begin
        lost_d     = lost_q;
        drop_cnt_d = drop_clr_i ? '0 : drop_cnt_q;
        if (drop) begin
            lost_d = 1'b1;
            if (drop_cnt_d != {DropCntWidth{1'b1}}) drop_cnt_d = drop_cnt_d + 1'b1;
        end else if (push) begin
            lost_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= TRACE_HDR;
            lost_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lost_q     <= lost_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
// tb/tb_ibex_rvfi_trace_buffer.sv - self-checking bench for ibex_rvfi_trace_buffer
module tb_ibex_rvfi_trace_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trace_en;
    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic        rvfi_trap, rvfi_halt, rvfi_intr;
    logic [1:0]  rvfi_mode;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata, rvfi_pc_rdata, rvfi_mem_addr;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
    logic        trace_valid, trace_ready, trace_last, drop_clr;
    logic [31:0] trace_data;
    logic [15:0] drop_cnt;
    logic [2:0]  level;

    ibex_rvfi_trace_buffer #(.Depth(DEPTH), .DropCntWidth(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .trace_en_i(trace_en),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
        .rvfi_mode(rvfi_mode), .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_mem_addr(rvfi_mem_addr),
        .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .trace_valid_o(trace_valid), .trace_ready_i(trace_ready),
        .trace_data_o(trace_data), .trace_last_o(trace_last),
        .drop_clr_i(drop_clr), .drop_cnt_o(drop_cnt), .level_o(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] order;
        logic [31:0] pc, insn, wdata, maddr;
        logic [4:0]  rd;
        logic [3:0]  rmask, wmask;
        logic        trap, intr, halt;
        logic [1:0]  mode;
        logic        lost;
    } m_rec_t;

    m_rec_t      mq[$];
    int          widx;
    logic        mlost;
    logic [15:0] mdrop;

    int checks = 0;
    int errors = 0;
    logic [31:0] got[$];
    logic        got_last[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit has_mem(m_rec_t r);
        return (r.rmask != 0) || (r.wmask != 0);
    endfunction

    function automatic int nwords(m_rec_t r);
        return has_mem(r) ? 5 : 4;
    endfunction

    function automatic logic [31:0] mword(m_rec_t r, int i);
        logic [31:0] h;
        h = 32'(r.rd) * 32'h0800_0000 + 32'(r.rmask) * 32'h0080_0000
          + 32'(r.wmask) * 32'h0008_0000 + 32'(r.trap) * 32'h0004_0000
          + 32'(r.intr) * 32'h0002_0000 + 32'(r.halt) * 32'h0001_0000
          + 32'(r.mode) * 32'h0000_4000 + 32'(r.lost) * 32'h0000_2000
          + (has_mem(r) ? 32'h1000 : 32'h0) + 32'(r.order);
        case (i)
            0:       return h;
            1:       return r.pc;
            2:       return r.insn;
            3:       return (r.rd == 0) ? 32'd0 : r.wdata;
            default: return r.maddr;
        endcase
    endfunction

    // Reference model: records queue up, head word index advances on each accepted word.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            widx  = 0;
            mlost = 1'b0;
            mdrop = 16'd0;
        end else begin
            bit hs, plast, full, take, dropped;
            m_rec_t r;
            hs      = (mq.size() > 0) && trace_ready;
            plast   = hs && (widx == nwords(mq[0]) - 1);
            full    = (mq.size() == DEPTH);
            take    = rvfi_valid && trace_en && (!full || plast);
            dropped = rvfi_valid && trace_en && full && !plast;
            if (hs) begin
                if (plast) begin
                    void'(mq.pop_front());
                    widx = 0;
                end else widx++;
            end
            if (take) begin
                r = '{order: rvfi_order[11:0], pc: rvfi_pc_rdata, insn: rvfi_insn,
                      wdata: rvfi_rd_wdata, maddr: rvfi_mem_addr, rd: rvfi_rd_addr,
                      rmask: rvfi_mem_rmask, wmask: rvfi_mem_wmask, trap: rvfi_trap,
                      intr: rvfi_intr, halt: rvfi_halt, mode: rvfi_mode, lost: mlost};
                mq.push_back(r);
                mlost = 1'b0;
            end
            if (drop_clr) mdrop = 16'd0;
            if (dropped) begin
                mlost = 1'b1;
                if (mdrop != 16'hFFFF) mdrop++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid", trace_valid, 0);
            check("rst_data", trace_data, 0);
            check("rst_level", level, 0);
        end else begin
            check("valid", trace_valid, mq.size() > 0);
            check("level", level, mq.size());
            check("drop_cnt", drop_cnt, mdrop);
            if (mq.size() > 0) begin
                check("data", trace_data, mword(mq[0], widx));
                check("last", trace_last, widx == nwords(mq[0]) - 1);
            end
            if (trace_valid && trace_ready) begin
                got.push_back(trace_data);
                got_last.push_back(trace_last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] insn, input logic [4:0] rd,
                          input logic [31:0] wdata, input logic [3:0] rmask,
                          input logic [31:0] maddr, input logic [11:0] order);
        rvfi_valid = 1'b1; rvfi_pc_rdata = pc; rvfi_insn = insn; rvfi_rd_addr = rd;
        rvfi_rd_wdata = wdata; rvfi_mem_rmask = rmask; rvfi_mem_wmask = 4'd0;
        rvfi_mem_addr = maddr; rvfi_order = {52'd0, order};
        tick();
        rvfi_valid = 1'b0;
    endtask

    initial begin
        rst_n = 0; trace_en = 1; rvfi_valid = 0; rvfi_order = 0; rvfi_insn = 0;
        rvfi_trap = 0; rvfi_halt = 0; rvfi_intr = 0; rvfi_mode = 0; rvfi_rd_addr = 0;
        rvfi_rd_wdata = 0; rvfi_pc_rdata = 0; rvfi_mem_addr = 0; rvfi_mem_rmask = 0;
        rvfi_mem_wmask = 0; trace_ready = 0; drop_clr = 0;
        repeat (3) tick();
        check("reset_last", trace_last, 0);
        check("reset_drop", drop_cnt, 0);
        rst_n = 1;
        tick();

        // ALU retire
        trace_ready = 1; got.delete(); got_last.delete();
        retire(32'h80, 32'h00500093, 5'd1, 32'd5, 4'd0, 32'd0, 12'd7);
        repeat (6) tick();
        check("alu_nwords", got.size(), 4);
        if (got.size() == 4) begin
            check("alu_hdr", got[0], 32'h08000007);
            check("alu_pc", got[1], 32'h80);
            check("alu_insn", got[2], 32'h00500093);
            check("alu_wdata", got[3], 32'd5);
            check("alu_last3", got_last[3], 1);
            check("alu_last2", got_last[2], 0);
        end

        // Load retire
        got.delete(); got_last.delete();
        retire(32'h84, 32'h00002103, 5'd2, 32'h1234, 4'hF, 32'h1000, 12'd8);
        repeat (7) tick();
        check("ld_nwords", got.size(), 5);
        if (got.size() == 5) begin
            check("ld_hdr", got[0], 32'h17801008);
            check("ld_wdata", got[3], 32'h1234);
            check("ld_last3", got_last[3], 0);
            check("ld_mem", got[4], 32'h1000);
            check("ld_last4", got_last[4], 1);
        end

        // Backpressure mid-record
        trace_ready = 0;
        retire(32'h80, 32'h00500093, 5'd1, 32'd5, 4'd0, 32'd0, 12'd9);
        got.delete(); got_last.delete();
        trace_ready = 1;
        tick();
        trace_ready = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", trace_valid, 1);
            check("bp_data", trace_data, 32'h80);
        end
        trace_ready = 1;
        repeat (5) tick();
        check("bp_nwords", got.size(), 4);
        if (got.size() == 4) begin
            check("bp_hdr", got[0], 32'h08000009);
            check("bp_pc", got[1], 32'h80);
            check("bp_insn", got[2], 32'h00500093);
            check("bp_wdata", got[3], 32'd5);
        end

        // Overflow: six retires into a four-entry FIFO
        trace_ready = 0;
        for (int i = 0; i < 6; i++)
            retire(32'h100 + 32'(i * 4), 32'h13, 5'd1, 32'd1, 4'd0, 32'd0, 12'(20 + i));
        check("ovf_level", level, 4);
        check("ovf_drop", drop_cnt, 2);

        // Full FIFO accepts when the head record completes in the same cycle
        got.delete(); got_last.delete();
        trace_ready = 1;
        repeat (3) tick();
        retire(32'h200, 32'h13, 5'd1, 32'd1, 4'd0, 32'd0, 12'd26);
        check("coin_level", level, 4);
        check("coin_drop", drop_cnt, 2);
        repeat (20) tick();
        check("coin_nwords", got.size(), 20);
        if (got.size() == 20) begin
            check("ovf_hdr0", got[0], 32'h08000014);
            check("ovf_hdr1", got[4], 32'h08000015);
            check("ovf_hdr2", got[8], 32'h08000016);
            check("ovf_hdr3", got[12], 32'h08000017);
            check("ovf_hdr_lost", got[16], 32'h0800201A);
        end

        // Counter saturation and clear
        trace_ready = 0; rvfi_valid = 1; rvfi_mem_rmask = 0;
        repeat (65540) tick();
        check("sat_drop", drop_cnt, 16'hFFFF);
        drop_clr = 1;
        tick();
        check("clr_with_drop", drop_cnt, 1);
        rvfi_valid = 0;
        tick();
        check("clr_alone", drop_cnt, 0);
        drop_clr = 0;

        // Reset mid-record
        trace_ready = 1;
        repeat (2) tick();
        rst_n = 0;
        #1;
        check("mrst_valid", trace_valid, 0);
        check("mrst_data", trace_data, 0);
        check("mrst_last", trace_last, 0);
        check("mrst_level", level, 0);
        check("mrst_drop", drop_cnt, 0);
        tick();
        rst_n = 1;
        tick();
        check("post_rst_valid", trace_valid, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rvfi_valid     = ($urandom_range(0, 1) == 1);
            trace_en       = ($urandom_range(0, 99) < 85);
            trace_ready    = ($urandom_range(0, 99) < 60);
            drop_clr       = ($urandom_range(0, 99) < 3);
            rvfi_order     = {$urandom, $urandom};
            rvfi_insn      = $urandom;
            rvfi_pc_rdata  = $urandom;
            rvfi_rd_wdata  = $urandom;
            rvfi_mem_addr  = $urandom;
            rvfi_rd_addr   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rvfi_mem_rmask = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            rvfi_mem_wmask = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            rvfi_trap      = 1'($urandom);
            rvfi_halt      = 1'($urandom);
            rvfi_intr      = 1'($urandom);
            rvfi_mode      = 2'($urandom);
            tick();
        end
        rvfi_valid = 0; drop_clr = 0; trace_ready = 1;
        repeat (40) tick();
        check("drain_level", level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibex_rvfi_trace_buffer.md
Name: ibex_rvfi_trace_buffer

Overview:
Downstream consumer of the core's RVFI retirement port, sitting beside the text tracer. Captures a subset of each retired-instruction record into a small record FIFO. Streams each record out as 32-bit words over a valid/ready interface to an off-core trace sink (DMA, UART bridge, debug RAM). Counts and flags records dropped on overflow, so the sink can detect gaps.

Parameters:
Depth, 4, record FIFO entries; power of two, >= 2
DropCntWidth, 16, width of the saturating drop counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
trace_en_i  in  1  capture enable; gates pushes only
rvfi_valid  in  1  retirement strobe
rvfi_order  in  64  retirement order; only [11:0] captured
rvfi_insn  in  32  instruction word
rvfi_trap  in  1  trap flag
rvfi_halt  in  1  halt flag
rvfi_intr  in  1  first instruction of a handler
rvfi_mode  in  2  privilege mode
rvfi_rd_addr  in  5  destination register
rvfi_rd_wdata  in  32  destination write data
rvfi_pc_rdata  in  32  PC of retired instruction
rvfi_mem_addr  in  32  memory access address
rvfi_mem_rmask  in  4  read byte mask
rvfi_mem_wmask  in  4  write byte mask
trace_valid_o  out  1  output word valid
trace_ready_i  in  1  sink accepts word
trace_data_o  out  32  output word
trace_last_o  out  1  final word of current record
drop_clr_i  in  1  clear drop counter
drop_cnt_o  out  DropCntWidth  saturating count of dropped records
level_o  out  $clog2(Depth)+1  FIFO occupancy

Behaviour:
- Reset state: trace_valid_o=0, trace_last_o=0, trace_data_o=0, drop_cnt_o=0, level_o=0, lost flag=0, serializer in HDR.
- Push condition: rvfi_valid && trace_en_i && (!full || pop_rec).
  - pop_rec = last word handshaked this cycle. A full FIFO therefore still accepts when a record completes in the same cycle.
- Drop condition: rvfi_valid && trace_en_i && full && !pop_rec. On drop:
  - drop_cnt_o increments, saturating at all-ones.
  - Sticky lost flag is set.
- Lost flag is stored into the next pushed record, then cleared in that same cycle.
- drop_clr_i zeroes drop_cnt_o. If a drop occurs in the same cycle, the counter becomes 1. drop_clr_i does not affect the lost flag.
- rvfi_valid with trace_en_i=0 is ignored: no push, no drop count.
- Latency: a record pushed in cycle N may present its header with trace_valid_o=1 in cycle N+1 at the earliest.
- Word format, in order:
  - HDR: [31:27] rd_addr, [26:23] mem_rmask, [22:19] mem_wmask, [18] trap, [17] intr, [16] halt, [15:14] mode, [13] lost, [12] mem (= |rmask or |wmask), [11:0] order[11:0].
  - PC: pc_rdata.
  - INSN: insn.
  - WDATA: rd_wdata; 0 when rd_addr==0.
  - MEM: mem_addr; present only if mem=1.
- Serializer FSM: HDR -> PC -> INSN -> WDATA -> (mem ? MEM : HDR), and MEM -> HDR.
  - A state advances only on trace_valid_o && trace_ready_i.
  - trace_last_o=1 in WDATA when mem=0, and in MEM.
  - The record is popped on the last-word handshake.
- trace_valid_o = FIFO non-empty. trace_data_o and trace_last_o are combinational from the FIFO head and FSM state.
- Stability: once trace_valid_o=1 it stays high, with trace_data_o and trace_last_o stable, until trace_ready_i. Later pushes never disturb the head entry.
- Deasserting trace_en_i mid-record does not abort output. Queued records drain fully.
- Pointers wrap modulo Depth. An extra wrap bit distinguishes full from empty. level_o is in the range 0..Depth.
- Reset asserted mid-record discards the FIFO contents. No partial record is emitted after reset release.

Decomposition:
- ibex_pkg gains:
  - trace_rec_t packed struct (order[11:0], pc, insn, rd_wdata, mem_addr, rd_addr, rmask, wmask, trap, intr, halt, mode, lost).
  - trace_word_e enum {TRACE_HDR, TRACE_PC, TRACE_INSN, TRACE_WDATA, TRACE_MEM}.
  - Header bit-position localparams.
- One sub-module: ibex_trace_fifo. It is a parameterised synchronous FIFO of trace_rec_t with push/pop/full/empty/level, async active-low reset.
- Serializer FSM and drop logic live in the top.

Test Plan:
- ALU retire: pc=0x80, insn=0x00500093, rd=1, wdata=5, masks=0, order=7, ready held 1 -> 4 words on consecutive cycles: hdr=0x08000007, 0x80, 0x00500093, 5; last on word 4.
- Load retire: rmask=0xF, mem_addr=0x1000 -> header bit12=1 and bits[26:23]=0xF; 5 words; last only on word 5 = 0x1000.
- Backpressure: ready=0 for 10 cycles mid-record -> valid stays 1 and data is unchanged across all 10 cycles; no words are skipped.
- Overflow: ready=0, 6 back-to-back retires with Depth=4 -> level_o=4, drop_cnt_o=2; after draining, only the 5th accepted record's header has bit13=1.
- Full+pop coincidence: FIFO full, last-word handshake in the same cycle as rvfi_valid -> record accepted, drop_cnt_o unchanged, level_o stays 4.
- Counter saturation and clear: force 0xFFFF drops, then one more -> stays 0xFFFF; drop_clr_i together with a drop -> 1; drop_clr_i alone -> 0. Reset mid-stream -> all outputs 0 next cycle.
